lcd_bus_decoder: RTL and testbench

Receive-side decoder for the HD44780-style LCD bus that the CPU bit-bangs through its memory-mapped LCD register (E, RW, RS, DB7..DB4). It sits beside the board top level, taps the same four-bit bus the CPU drives, and reassembles each write cycle into complete command or data bytes. Decoded bytes are queued in a small FIFO for a consumer such as UART debug echo or a simulation scoreboard. It also tracks the controller's 8-bit power-on mode, the switch to 4-bit mode, and nibble pairing.

---
 rtl/lcd_bus_decoder.sv | 253 +++++++++++++++++++++++++
 tb/tb_lcd_bus_decoder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_decoder.sv
// lcd_bus_decoder: receive-side decoder for an HD44780-style 4-bit LCD bus.
// Taps the bus the CPU bit-bangs and rebuilds each write cycle into a byte.
// Starts in the controller's 8-bit power-on mode. Moves to 4-bit nibble
// pairing after a 0x2 function-set command. Queues bytes in a small FIFO.
//
// Optional feature: define LCD_DEC_BUSY_EN to emulate the busy flag and
// read-back nibble. With the macro undefined, busy and rd_db are tied low.
//
// Output handshake: out_valid is high whenever the FIFO holds a byte, and
// out_data/out_rs/out_mode8 describe that head byte. The head is consumed at
// a rising clk edge where out_valid & out_ready. out_valid never depends
// combinationally on out_ready.
module lcd_bus_decoder #(
  parameter int DEPTH       = 4,
  parameter int MIN_E_HIGH  = 2,
  parameter int TIMEOUT     = 1024,
  parameter int BUSY_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_e,
  input  logic       lcd_rw,
  input  logic       lcd_rs,
  input  logic [3:0] lcd_db,
  input  logic       resync,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_rs,
  output logic       out_mode8,
  output logic       mode4,
  output logic       err_overflow,
  output logic       err_timeout,
  input  logic       clr_err,
  output logic       busy,
  output logic [3:0] rd_db
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int EW = $clog2(MIN_E_HIGH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [EW-1:0] E_SAT  = EW'(MIN_E_HIGH);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    M8 = 2'd0,  // 8-bit power-on mode, one strobe per byte
    H4 = 2'd1,  // 4-bit mode, waiting for the high nibble
    L4 = 2'd2   // 4-bit mode, holding the high nibble
  } state_t;

  // ---------------- strobe detection ----------------
  logic          e_q;
  logic          rw_q;
  logic          rs_q;
  logic [3:0]    db_q;
  logic [EW-1:0] e_cnt;
  logic          strobe;
  logic          wr_strobe;

  // Register the bus and count consecutive E-high cycles, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_q   <= 1'b0;
      rw_q  <= 1'b0;
      rs_q  <= 1'b0;
      db_q  <= 4'h0;
      e_cnt <= '0;
    end else begin
      e_q  <= lcd_e;
      rw_q <= lcd_rw;
      rs_q <= lcd_rs;
      db_q <= lcd_db;
      if (!lcd_e)
        e_cnt <= '0;
      else if (e_cnt < E_SAT)
        e_cnt <= e_cnt + 1'b1;
    end
  end

  // A strobe is the falling edge of a sufficiently long E pulse.
  assign strobe    = e_q & ~lcd_e & (e_cnt >= E_SAT);
  assign wr_strobe = strobe & ~rw_q;

  // ---------------- mode FSM ----------------
  state_t        state_q;
  state_t        state_d;
  logic [3:0]    hi_q;
  logic          hi_rs_q;
  logic [TW-1:0] to_cnt;
  logic          hi_ld;
  logic          gen;
  logic [7:0]    gen_data;
  logic          gen_rs;
  logic          gen_mode8;
  logic          to_evt;

  // State register, held high nibble and L4 timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= M8;
      hi_q    <= 4'h0;
      hi_rs_q <= 1'b0;
      to_cnt  <= '0;
    end else begin
      state_q <= state_d;
      if (hi_ld) begin
        hi_q    <= db_q;
        hi_rs_q <= rs_q;
        to_cnt  <= '0;
      end else if (state_q == L4 && to_cnt != TO_MAX) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  // Next state and byte generation; resync overrides any same-cycle strobe.
  always_comb begin
    state_d   = state_q;
    hi_ld     = 1'b0;
    gen       = 1'b0;
    gen_data  = 8'h00;
    gen_rs    = 1'b0;
    gen_mode8 = 1'b0;
    to_evt    = 1'b0;
    if (resync) begin
      state_d = H4;
    end else begin
      case (state_q)
        M8: begin
          if (wr_strobe) begin
            gen       = 1'b1;
            gen_data  = {db_q, 4'h0};
            gen_rs    = rs_q;
            gen_mode8 = 1'b1;
            if (!rs_q && db_q == 4'h2)
              state_d = H4;
          end
        end
        H4: begin
          if (wr_strobe) begin
            hi_ld   = 1'b1;
            state_d = L4;
          end
        end
        L4: begin
          if (wr_strobe) begin
            gen      = 1'b1;
            gen_data = {hi_q, db_q};
            gen_rs   = hi_rs_q;
            state_d  = H4;
          end else if (to_cnt == TO_MAX) begin
            to_evt  = 1'b1;
            state_d = H4;
          end
        end
        default: state_d = M8;
      endcase
    end
  end

  assign mode4 = (state_q != M8);

  // ---------------- output FIFO ----------------
  logic [9:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        pop;
  logic        push_ok;
  logic        drop;
  logic [9:0]  head;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign out_valid = (wr_ptr != rd_ptr);
  assign pop     = out_valid & out_ready;
  assign push_ok = gen & (~full | pop);
  assign drop    = gen & full & ~pop;
  assign head    = mem[rd_ptr[AW-1:0]];

  assign out_data  = out_valid ? head[7:0] : 8'h00;
  assign out_rs    = out_valid & head[8];
  assign out_mode8 = out_valid & head[9];

  // FIFO storage; contents are only visible through the valid-gated head.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr[AW-1:0]] <= {gen_mode8, gen_rs, gen_data};
  end

  // FIFO pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Sticky error flags; a new error beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_overflow <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      if (drop)         err_overflow <= 1'b1;
      else if (clr_err) err_overflow <= 1'b0;
      if (to_evt)       err_timeout  <= 1'b1;
      else if (clr_err) err_timeout  <= 1'b0;
    end
  end

  // ---------------- busy / read-back emulation ----------------
`ifdef LCD_DEC_BUSY_EN
  localparam int BW = $clog2(BUSY_CYCLES + 1);
  localparam logic [BW-1:0] BUSY_LD = BW'(BUSY_CYCLES);

  logic [BW-1:0] busy_cnt;
  logic          rd_phase;
  logic          rd_strobe;

  assign rd_strobe = strobe & rw_q;

  // Busy countdown restarts on every generated byte, pushed or dropped.
  always_ff @(posedge clk) begin
    if (rst)
      busy_cnt <= '0;
    else if (gen)
      busy_cnt <= BUSY_LD;
    else if (busy_cnt != '0)
      busy_cnt <= busy_cnt - 1'b1;
  end

  // Read phase: 0 = next read returns the high nibble (busy flag).
  always_ff @(posedge clk) begin
    if (rst)
      rd_phase <= 1'b0;
    else if (resync || wr_strobe)
      rd_phase <= 1'b0;
    else if (rd_strobe)
      rd_phase <= ~rd_phase;
  end

  assign busy  = (busy_cnt != '0);
  assign rd_db = (lcd_rw && !rd_phase) ? {busy, 3'b000} : 4'h0;
`else
  // Busy emulation absent: flag is always clear regardless of BUSY_CYCLES.
  assign busy  = (BUSY_CYCLES < 0);
  assign rd_db = 4'h0;
`endif

endmodule

// File: tb/tb_lcd_bus_decoder.sv
// tb_lcd_bus_decoder: directed bench for lcd_bus_decoder.
// Inputs change on the falling clk edge; outputs are sampled there too.
module tb_lcd_bus_decoder;

  localparam int DEPTH       = 4;
  localparam int MIN_E_HIGH  = 2;
  localparam int TIMEOUT     = 1024;
  localparam int BUSY_CYCLES = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       lcd_e;
  logic       lcd_rw;
  logic       lcd_rs;
  logic [3:0] lcd_db;
  logic       resync;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_rs;
  logic       out_mode8;
  logic       mode4;
  logic       err_overflow;
  logic       err_timeout;
  logic       clr_err;
  logic       busy;
  logic [3:0] rd_db;

  int n_checks = 0;
  int n_errors = 0;
  logic [9:0] exp_q[$];

  lcd_bus_decoder #(
    .DEPTH(DEPTH), .MIN_E_HIGH(MIN_E_HIGH), .TIMEOUT(TIMEOUT), .BUSY_CYCLES(BUSY_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .lcd_e(lcd_e), .lcd_rw(lcd_rw), .lcd_rs(lcd_rs),
    .lcd_db(lcd_db), .resync(resync), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rs(out_rs), .out_mode8(out_mode8), .mode4(mode4),
    .err_overflow(err_overflow), .err_timeout(err_timeout), .clr_err(clr_err),
    .busy(busy), .rd_db(rd_db)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // Global time limit so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "time limit");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One E pulse of 'hi' cycles; returns on the negedge where E drops.
  task automatic strobe(input logic rw, input logic rs, input logic [3:0] db, input int hi);
    lcd_rw = rw;
    lcd_rs = rs;
    lcd_db = db;
    lcd_e  = 1'b1;
    tick(hi);
    lcd_e  = 1'b0;
  endtask

  // 8-bit mode write: byte is {nib,0} with mode8 set.
  task automatic send_m8(input logic rs, input logic [3:0] nib);
    strobe(1'b0, rs, nib, 3);
    tick(2);
    exp_q.push_back({1'b1, rs, nib, 4'h0});
  endtask

  // 4-bit mode write: two nibbles, high first.
  task automatic send_byte(input logic rs, input logic [7:0] b);
    strobe(1'b0, rs, b[7:4], 3);
    tick(2);
    strobe(1'b0, rs, b[3:0], 3);
    tick(2);
    exp_q.push_back({1'b0, rs, b});
  endtask

  // Scoreboard: wait (bounded) for the head, compare, then pop it.
  task automatic expect_byte(input string tag);
    logic [9:0] e;
    int w;
    w = 0;
    while (!out_valid && w < 20) begin
      tick(1);
      w++;
    end
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    if (!out_valid) begin
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      return;
    end
    check(tag, {22'd0, out_mode8, out_rs, out_data}, {22'd0, e});
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; lcd_e = 1'b0; lcd_rw = 1'b0; lcd_rs = 1'b0; lcd_db = 4'h0;
    resync = 1'b0; out_ready = 1'b0; clr_err = 1'b0;
    tick(3);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data",  {22'd0, out_mode8, out_rs, out_data}, 32'd0);
    check("rst_flags", {28'd0, mode4, err_overflow, err_timeout, busy}, 32'd0);
    check("rst_rd_db", {28'd0, rd_db}, 32'd0);
    rst = 1'b0;
    tick(1);

    // Power-on init sequence: three 0x3 then 0x2 in 8-bit mode.
    send_m8(1'b0, 4'h3);
    send_m8(1'b0, 4'h3);
    send_m8(1'b0, 4'h3);
    check("init_still8", {31'd0, mode4}, 32'd0);
    send_m8(1'b0, 4'h2);
    check("init_mode4", {31'd0, mode4}, 32'd1);
    for (int i = 0; i < 4; i++) expect_byte($sformatf("init_b%0d", i));

    // 4-bit data byte 0x41 and its latency from the second E fall.
    strobe(1'b0, 1'b1, 4'h4, 3);
    tick(2);
    strobe(1'b0, 1'b1, 4'h1, 3);
    check("lat_before", {31'd0, out_valid}, 32'd0);
    tick(1);
    check("lat_after", {31'd0, out_valid}, 32'd1);
    exp_q.push_back({1'b0, 1'b1, 8'h41});
    expect_byte("data_41");

    // 1-cycle E pulse is ignored; 2-cycle pulses are decoded.
    strobe(1'b0, 1'b0, 4'hF, 1);
    tick(3);
    check("short_novalid", {31'd0, out_valid}, 32'd0);
    strobe(1'b0, 1'b1, 4'h4, MIN_E_HIGH);
    tick(2);
    strobe(1'b0, 1'b1, 4'h2, MIN_E_HIGH);
    tick(2);
    exp_q.push_back({1'b0, 1'b1, 8'h42});
    expect_byte("min_pulse_42");

    // Orphan high nibble times out.
    strobe(1'b0, 1'b0, 4'h5, 3);
    tick(TIMEOUT - 10);
    check("to_early", {31'd0, err_timeout}, 32'd0);
    tick(20);
    check("to_set", {31'd0, err_timeout}, 32'd1);
    check("to_nobyte", {31'd0, out_valid}, 32'd0);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("to_clr", {31'd0, err_timeout}, 32'd0);
    send_byte(1'b0, 8'h67);
    expect_byte("after_to_67");

    // resync drops a held nibble and realigns on the next high nibble.
    strobe(1'b0, 1'b0, 4'hA, 3);
    tick(2);
    resync = 1'b1;
    tick(1);
    resync = 1'b0;
    send_byte(1'b0, 8'h58);
    expect_byte("resync_58");
    check("resync_noerr", {31'd0, err_timeout}, 32'd0);

    // Overflow: four bytes fill the FIFO, the fifth is dropped.
    send_byte(1'b0, 8'h11);
    send_byte(1'b1, 8'h22);
    send_byte(1'b0, 8'h33);
    send_byte(1'b1, 8'h44);
    check("ovf_before", {31'd0, err_overflow}, 32'd0);
    strobe(1'b0, 1'b0, 4'h5, 3);
    tick(2);
    strobe(1'b0, 1'b0, 4'h5, 3);
    tick(2);
    check("ovf_set", {31'd0, err_overflow}, 32'd1);
    check("cmd3x_mode4", {31'd0, mode4}, 32'd1);
    for (int i = 0; i < 4; i++) expect_byte($sformatf("ovf_b%0d", i));
    check("ovf_empty", {31'd0, out_valid}, 32'd0);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("ovf_clr", {31'd0, err_overflow}, 32'd0);

    // Reset mid-nibble: back to 8-bit mode, no error.
    strobe(1'b0, 1'b0, 4'hC, 3);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("midrst_mode", {29'd0, mode4, err_timeout, out_valid}, 32'd0);
    send_m8(1'b1, 4'h5);
    expect_byte("midrst_m8_50");

`ifdef LCD_DEC_BUSY_EN
    // Busy flag on the high-nibble read, cleared after BUSY_CYCLES.
    send_m8(1'b1, 4'h6);
    check("busy_high", {31'd0, busy}, 32'd1);
    lcd_rw = 1'b1; lcd_e = 1'b1;
    tick(1);
    check("rd_busy", {28'd0, rd_db}, 32'h8);
    tick(2);
    lcd_e = 1'b0;
    tick(1);
    lcd_rw = 1'b0;
    expect_byte("busy_byte_60");
    tick(BUSY_CYCLES + 5);
    check("busy_low", {31'd0, busy}, 32'd0);
    strobe(1'b1, 1'b0, 4'h0, 3);
    tick(1);
    lcd_rw = 1'b1; lcd_e = 1'b1;
    tick(1);
    check("rd_idle", {28'd0, rd_db}, 32'h0);
    lcd_e = 1'b0;
    tick(1);
    lcd_rw = 1'b0;
`else
    // Without busy emulation a read shows nothing and changes nothing.
    lcd_rw = 1'b1; lcd_e = 1'b1;
    tick(1);
    check("rd_db_off", {27'd0, busy, rd_db}, 32'd0);
    tick(2);
    lcd_e = 1'b0;
    tick(2);
    lcd_rw = 1'b0;
    check("rd_nobyte", {30'd0, mode4, out_valid}, 32'd0);
`endif

    check("sb_drained", exp_q.size(), 32'd0);
    tick(2);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
